mem_lsu: RTL and testbench



---
 rtl/mem_lsu.sv | 167 ++++++++++++++++
 tb/tb_mem_lsu.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// Load/store unit: aligns MEM-stage accesses onto a valid/ready dword bus and stalls the pipe until done.
// Optional watchdog abort is compiled in when LSU_TIMEOUT_EN is defined.
module mem_lsu #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              stall,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              misalign,
  output logic              bus_err,
  output logic              bus_valid,
  input  logic              bus_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [7:0]        bus_wmask,
  output logic [63:0]       bus_wdata,
  input  logic              bus_rvalid,
  input  logic [63:0]       bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            r_state;
  logic [2:0]        r_off;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_bus_addr;
  logic              r_bus_we;
  logic [7:0]        r_bus_wmask;
  logic [63:0]       r_bus_wdata;
  logic [63:0]       r_rdata;

  logic [2:0]        w_off;
  logic [7:0]        w_wmask;
  logic              w_misaligned;
  logic              w_accept;
  logic              w_timeout;

  assign w_off = req_addr[2:0];

  always_comb begin
    w_misaligned = 1'b0;
    w_wmask      = 8'hFF;
    case (req_size)
      2'd0:    w_wmask = 8'h01 << w_off;
      2'd1:    begin w_misaligned = w_off[0];    w_wmask = 8'h03 << w_off; end
      2'd2:    begin w_misaligned = |w_off[1:0]; w_wmask = 8'h0F << w_off; end
      default: begin w_misaligned = |w_off;      w_wmask = 8'hFF;          end
    endcase
  end

  function automatic logic [63:0] f_extend(input logic [63:0] raw, input logic [2:0] off,
                                           input logic [1:0] size, input logic zext);
    logic [63:0] t;
    t = raw >> {off, 3'b000};
    case (size)
      2'd0:    return zext ? {56'd0, t[7:0]}  : {{56{t[7]}},  t[7:0]};
      2'd1:    return zext ? {48'd0, t[15:0]} : {{48{t[15]}}, t[15:0]};
      2'd2:    return zext ? {32'd0, t[31:0]} : {{32{t[31]}}, t[31:0]};
      default: return t;
    endcase
  endfunction

  // Stall must rise in the accept cycle itself so MEM holds the request it just presented.
  assign w_accept   = (r_state == S_IDLE) && req_valid && !w_misaligned;
  assign stall      = w_accept || (r_state == S_REQ) || (r_state == S_WAIT);
  assign misalign   = (r_state == S_IDLE) && req_valid && w_misaligned;
  assign bus_valid  = (r_state == S_REQ);
  assign resp_valid = (r_state == S_DONE);
  assign resp_rdata = r_rdata;
  assign bus_addr   = r_bus_addr;
  assign bus_we     = r_bus_we;
  assign bus_wmask  = r_bus_wmask;
  assign bus_wdata  = r_bus_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_off       <= '0;
      r_size      <= '0;
      r_unsigned  <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_we    <= 1'b0;
      r_bus_wmask <= '0;
      r_bus_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_off       <= w_off;
            r_size      <= req_size;
            r_unsigned  <= req_unsigned;
            r_bus_addr  <= {req_addr[ADDR_W-1:3], 3'b000};
            r_bus_we    <= req_we;
            r_bus_wmask <= req_we ? w_wmask : 8'h00;
            r_bus_wdata <= req_wdata << {w_off, 3'b000};
            r_state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus_ready) begin
            if (r_bus_we) begin
              r_rdata <= '0;
              r_state <= S_DONE;
            end else begin
              r_state <= S_WAIT;
            end
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_state <= S_DONE;
          end
        end
        S_WAIT: begin
          if (bus_rvalid) begin
            r_rdata <= f_extend(bus_rdata, r_off, r_size, r_unsigned);
            r_state <= S_DONE;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] r_cnt;
  logic             r_bus_err;

  // Abort one cycle early so DONE lands exactly TIMEOUT_CYCLES after REQ entry.
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) &&
                     (((r_state == S_REQ) && !bus_ready) || ((r_state == S_WAIT) && !bus_rvalid));
  assign bus_err   = r_bus_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_bus_err <= w_timeout;
      if (w_accept)
        r_cnt <= '0;
      else if ((r_state == S_REQ) || (r_state == S_WAIT))
        r_cnt <= r_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign bus_err          = 1'b0;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Randomized bench for mem_lsu: a transaction-level timing/data model is checked every cycle,
// plus literal expectations for the directed cases.
module tb_mem_lsu;
  localparam int ADDR_W = 32;
`ifdef LSU_TIMEOUT_EN
  localparam int MAXDN = 3;
`else
  localparam int MAXDN = 8;
`endif

  logic              clk;
  logic              rst;
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              stall;
  logic              resp_valid;
  logic [63:0]       resp_rdata;
  logic              misalign;
  logic              bus_err;
  logic              bus_valid;
  logic              bus_ready;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;
  logic [7:0]        bus_wmask;
  logic [63:0]       bus_wdata;
  logic              bus_rvalid;
  logic [63:0]       bus_rdata;

  mem_lsu #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .misalign(misalign), .bus_err(bus_err),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_we(bus_we),
    .bus_wmask(bus_wmask), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
    end
  endtask

  function automatic logic m_mis(input logic [1:0] size, input logic [31:0] addr);
    return (addr % (32'd1 << size)) != 0;
  endfunction

  function automatic logic [7:0] m_mask(input logic we, input logic [1:0] size, input logic [2:0] off);
    logic [7:0] r;
    r = '0;
    if (we)
      for (int i = 0; i < (1 << size); i++) r[int'(off) + i] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] raw, input logic [2:0] off,
                                         input logic [1:0] size, input logic uns);
    int nb;
    logic [63:0] v;
    nb = 1 << size;
    v  = '0;
    for (int i = 0; i < nb; i++) v[8*i +: 8] = raw[8*(int'(off) + i) +: 8];
    if (!uns && nb < 8 && v[8*nb-1])
      for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // Current transaction as seen by the model
  logic        t_we, t_uns, t_idle, chk_en;
  logic [1:0]  t_size;
  logic [31:0] t_addr;
  logic [63:0] t_wdata, t_rdata, m_held;
  int          t_d, t_n, k;

  int          cap_stall, cap_bv, cap_hs, cap_resp, cap_mis, cap_resp_k;
  logic [31:0] cap_addr;
  logic [7:0]  cap_wmask;
  logic [63:0] cap_wdata, cap_rdata;

  always @(negedge clk) begin
    int   hs, dn;
    logic e_stall, e_bv, e_rv, e_mis;
    logic [2:0] off;
    if (rst) m_held = '0;
    if (chk_en) begin
      hs = 1 + t_d;
      dn = t_we ? hs + 1 : hs + t_n + 1;
      off = t_addr[2:0];
      e_stall = 1'b0; e_bv = 1'b0; e_rv = 1'b0; e_mis = 1'b0;
      if (!t_idle) begin
        if (m_mis(t_size, t_addr)) begin
          e_mis = (k == 0);
        end else begin
          e_stall = (k < dn);
          e_bv    = (k >= 1) && (k <= hs);
          e_rv    = (k == dn);
        end
      end
      if (e_rv) m_held = t_we ? 64'd0 : m_load(t_rdata, off, t_size, t_uns);
      chk("stall", stall, e_stall);
      chk("bus_valid", bus_valid, e_bv);
      chk("resp_valid", resp_valid, e_rv);
      chk("misalign", misalign, e_mis);
      chk("bus_err", bus_err, 1'b0);
      chk("resp_rdata", resp_rdata, m_held);
      if (e_bv) begin
        chk("bus_addr", bus_addr, {t_addr[31:3], 3'b000});
        chk("bus_we", bus_we, t_we);
        chk("bus_wmask", bus_wmask, m_mask(t_we, t_size, off));
        chk("bus_wdata", bus_wdata, t_wdata << (8 * off));
      end
      if (k == 0) begin
        cap_stall = 0; cap_bv = 0; cap_hs = 0; cap_resp = 0; cap_mis = 0; cap_resp_k = -1;
      end
      cap_stall += int'(stall);
      cap_bv    += int'(bus_valid);
      cap_hs    += int'(bus_valid && bus_ready);
      cap_mis   += int'(misalign);
      if (resp_valid) begin
        cap_resp++;
        cap_resp_k = k;
        cap_rdata  = resp_rdata;
      end
      if (bus_valid && k == 1) begin
        cap_addr  = bus_addr;
        cap_wmask = bus_wmask;
        cap_wdata = bus_wdata;
      end
    end
  end

  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                         input int d, input int n);
    int hs, dn, last;
    hs   = 1 + d;
    dn   = we ? hs + 1 : hs + n + 1;
    last = m_mis(size, addr) ? 0 : dn;
    for (int kk = 0; kk <= last; kk++) begin
      @(posedge clk); #1;
      t_we = we; t_size = size; t_uns = uns; t_addr = addr; t_wdata = wdata; t_rdata = rdata;
      t_d = d; t_n = n; t_idle = 1'b0; k = kk;
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      bus_ready = (kk == hs) || ((kk == 0 || kk == dn) && $urandom_range(0, 1) == 1);
      if (!we && kk == hs + n) begin
        bus_rvalid = 1'b1;
        bus_rdata  = rdata;
      end else begin
        bus_rvalid = (kk < hs || kk == dn) && $urandom_range(0, 2) == 0;
        bus_rdata  = {$urandom, $urandom};
      end
    end
    @(negedge clk); #1;
  endtask

  task automatic run_idle();
    @(posedge clk); #1;
    t_idle = 1'b1; k = 0;
    req_valid  = 1'b0;
    bus_ready  = $urandom_range(0, 1) == 1;
    bus_rvalid = $urandom_range(0, 1) == 1;
    bus_rdata  = {$urandom, $urandom};
  endtask

  initial begin
    int d5;
    rst = 1'b1; chk_en = 1'b0; t_idle = 1'b1; k = 0;
    t_we = 1'b0; t_uns = 1'b0; t_size = '0; t_addr = '0; t_wdata = '0; t_rdata = '0; t_d = 0; t_n = 1;
    req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_bus_valid", bus_valid, 1'b0);
    chk("rst_bus_addr", bus_addr, 64'd0);
    chk("rst_bus_wmask", bus_wmask, 64'd0);
    chk("rst_bus_wdata", bus_wdata, 64'd0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_bus_err", bus_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; chk_en = 1'b1;

    chk("model_lh", m_load(64'h8001_0000_0000_0000, 3'd6, 2'd1, 1'b0), 64'hFFFF_FFFF_FFFF_8001);
    chk("model_sb_mask", m_mask(1'b1, 2'd0, 3'd3), 64'h08);

    // SD, bus already ready
    run_txn(1'b1, 2'd3, 1'b0, 32'h8000_1008, 64'h1122_3344_5566_7788, 64'd0, 0, 1);
    chk("sd_addr", cap_addr, 64'h8000_1008);
    chk("sd_wmask", cap_wmask, 64'hFF);
    chk("sd_wdata", cap_wdata, 64'h1122_3344_5566_7788);
    chk("sd_stall_cycles", cap_stall, 2);
    chk("sd_resp_cycle", cap_resp_k, 2);
    // SB at offset 3
    run_txn(1'b1, 2'd0, 1'b0, 32'h8000_1003, 64'hAB, 64'd0, 0, 1);
    chk("sb_wmask", cap_wmask, 64'h08);
    chk("sb_wdata", cap_wdata, 64'h0000_0000_AB00_0000);
    chk("sb_addr", cap_addr, 64'h8000_1000);
    // LH / LHU, read data two cycles after accept
    run_txn(1'b0, 2'd1, 1'b0, 32'h8000_1006, 64'd0, 64'h8001_0000_0000_0000, 0, 2);
    chk("lh_rdata", cap_rdata, 64'hFFFF_FFFF_FFFF_8001);
    chk("lh_resp_cycle", cap_resp_k, 4);
    chk("lh_stall_cycles", cap_stall, 4);
    run_txn(1'b0, 2'd1, 1'b1, 32'h8000_1006, 64'd0, 64'h8001_0000_0000_0000, 0, 2);
    chk("lhu_rdata", cap_rdata, 64'h0000_0000_0000_8001);
    // misaligned LW
    run_txn(1'b0, 2'd2, 1'b0, 32'h8000_1002, 64'd0, 64'd0, 0, 1);
    chk("lw_mis_pulses", cap_mis, 1);
    chk("lw_mis_bus_valid", cap_bv, 0);
    chk("lw_mis_stall", cap_stall, 0);
    // bus_ready held low in REQ
    d5 = (MAXDN >= 5) ? 5 : 2;
    run_txn(1'b1, 2'd2, 1'b0, 32'h8000_2004, 64'hDEAD_BEEF, 64'd0, d5, 1);
    chk("bp_handshakes", cap_hs, 1);
    chk("bp_resp_count", cap_resp, 1);
    chk("bp_stall_cycles", cap_stall, d5 + 2);
    chk("bp_bus_valid_cycles", cap_bv, d5 + 1);

    for (int i = 0; i < 200; i++) begin
      logic [1:0]  sz;
      logic [31:0] a;
      int          d, n;
      sz = 2'($urandom_range(0, 3));
      a  = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
      d = $urandom_range(0, MAXDN / 2);
      n = $urandom_range(1, MAXDN - d);
      run_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
              {$urandom, $urandom}, {$urandom, $urandom}, d, n);
      if ($urandom_range(0, 4) == 0) run_idle();
    end

    // Reset while waiting for read data; the late rvalid must be dropped
    @(posedge clk); #1;
    chk_en = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_unsigned = 1'b0; req_addr = 32'h8000_3000;
    bus_ready = 1'b0; bus_rvalid = 1'b0;
    @(posedge clk); #1;
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0; req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    chk("mrst_stall", stall, 1'b0);
    chk("mrst_bus_valid", bus_valid, 1'b0);
    chk("mrst_resp_valid", resp_valid, 1'b0);
    chk("mrst_bus_addr", bus_addr, 64'd0);
    chk("mrst_bus_wdata", bus_wdata, 64'd0);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    chk("mrst_resp_valid2", resp_valid, 1'b0);
    chk("mrst_resp_rdata", resp_rdata, 64'd0);

`ifdef LSU_TIMEOUT_EN
    begin
      int rv_k, er_k, rv_cnt;
      rv_k = -1; er_k = -1; rv_cnt = 0;
      for (int kk = 0; kk < 8; kk++) begin
        @(posedge clk); #1;
        req_valid = (kk <= 5); req_we = 1'b0; req_size = 2'd3; req_addr = 32'h8000_4000;
        bus_ready = (kk == 1); bus_rvalid = 1'b0;
        @(negedge clk);
        chk("to_stall", stall, kk < 5);
        if (resp_valid) begin rv_k = kk; rv_cnt++; end
        if (bus_err) er_k = kk;
      end
      chk("to_resp_cycle", rv_k, 5);
      chk("to_bus_err_cycle", er_k, 5);
      chk("to_resp_count", rv_cnt, 1);
      chk("to_rdata", resp_rdata, 64'd0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
